// File: rtl/memoria_be_if.sv
// Bundles the request and response signals of the byte-enable dual-port memory.
// No latency of its own; it only carries signals between client and memory.
// No backpressure: the memory accepts a read and a write on every cycle.
interface memoria_be_if #(
    parameter int BUS_SIZE      = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int NUM_MEM_UNITS = 4
);
    logic                     read;
    logic                     write;
    logic [NUM_MEM_UNITS-1:0] byte_en;
    logic [BUS_SIZE-1:0]      data_in;
    logic [ADDR_WIDTH-1:0]    addressW;
    logic [ADDR_WIDTH-1:0]    addressR;
    logic [BUS_SIZE-1:0]      data_out;
    logic                     valid_out;
    logic                     unwritten;

    // Client side: issues requests and consumes read results.
    modport master (
        output read, write, byte_en, data_in, addressW, addressR,
        input  data_out, valid_out, unwritten
    );

    // Memory side.
    modport slave (
        input  read, write, byte_en, data_in, addressW, addressR,
        output data_out, valid_out, unwritten
    );
endinterface

// File: rtl/memoria_be.sv
// Dual-port memory with per-lane write enables, written-word tracking and a collision policy.
// Read latency is READ_LATENCY edges (1 or 2) from the sampled read to data_out/valid_out.
// No backpressure: one read and one write are accepted on every edge, so throughput is full.
module memoria_be #(
    parameter int BUS_SIZE       = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int NUM_MEM_UNITS  = 4,
    parameter int MEM_LENGTH     = 1 << ADDR_WIDTH,
    parameter int MEM_UNIT_WIDTH = BUS_SIZE / NUM_MEM_UNITS,
    parameter int READ_LATENCY   = 1,
    parameter bit WRITE_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_L,
    memoria_be_if.slave bus
);
    localparam int UW = MEM_UNIT_WIDTH;

    // Storage is deliberately not reset; written_q makes untouched words read as zero.
    logic [BUS_SIZE-1:0]   mem_q [MEM_LENGTH];
    logic [MEM_LENGTH-1:0] written_q, written_d;

    logic                wr_en;
    logic                collide;
    logic [BUS_SIZE-1:0] lane_mask;
    logic [BUS_SIZE-1:0] wr_base;
    logic [BUS_SIZE-1:0] wr_word;
    logic [BUS_SIZE-1:0] rd_dat;
    logic                rd_unw;

    // Result feeding the output register, taken straight from the array or from the extra stage.
    logic                out_vld;
    logic [BUS_SIZE-1:0] out_dat;
    logic                out_unw;

    logic                valid_out_q, valid_out_d;
    logic                unwritten_q, unwritten_d;
    logic [BUS_SIZE-1:0] data_out_q, data_out_d;

    // An all-zero byte_en is a no-op, so it neither writes nor marks the word written.
    assign wr_en   = bus.write && (bus.byte_en != '0);
    assign collide = wr_en && (bus.addressW == bus.addressR);

    // Expand the lane enables into a bit mask over the data word.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NUM_MEM_UNITS; i++) begin
            lane_mask[i*UW +: UW] = {UW{bus.byte_en[i]}};
        end
    end

    // Merge new lanes over the old word; a first write zero-fills the lanes it does not enable.
    always_comb begin
        wr_base   = written_q[bus.addressW] ? mem_q[bus.addressW] : '0;
        wr_word   = (bus.data_in & lane_mask) | (wr_base & ~lane_mask);
        written_d = written_q;
        if (wr_en) begin
            written_d[bus.addressW] = 1'b1;
        end
    end

    // Resolve the read word: prior content (zero if unwritten), or the merged word when
    // write-first and the same word is being written on this edge.
    always_comb begin
        rd_dat = written_q[bus.addressR] ? mem_q[bus.addressR] : '0;
        rd_unw = !written_q[bus.addressR];
        if (WRITE_FIRST && collide) begin
            rd_dat = wr_word;
            rd_unw = 1'b0;
        end
    end

    // Array write port; writes are ignored while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && reset_L) begin
            mem_q[bus.addressW] <= wr_word;
        end
    end

    // Written-word bitmap.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                s1_vld_q, s1_vld_d;
            logic                s1_unw_q, s1_unw_d;
            logic [BUS_SIZE-1:0] s1_dat_q, s1_dat_d;

            // Capture the resolved read into the intermediate stage.
            always_comb begin
                s1_vld_d = bus.read;
                s1_dat_d = s1_dat_q;
                s1_unw_d = s1_unw_q;
                if (bus.read) begin
                    s1_dat_d = rd_dat;
                    s1_unw_d = rd_unw;
                end
            end

            // Intermediate stage; reset drops any read still in flight.
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    s1_vld_q <= 1'b0;
                    s1_unw_q <= 1'b0;
                    s1_dat_q <= '0;
                end else begin
                    s1_vld_q <= s1_vld_d;
                    s1_unw_q <= s1_unw_d;
                    s1_dat_q <= s1_dat_d;
                end
            end

            assign out_vld = s1_vld_q;
            assign out_dat = s1_dat_q;
            assign out_unw = s1_unw_q;
        end else begin : g_lat1
            assign out_vld = bus.read;
            assign out_dat = rd_dat;
            assign out_unw = rd_unw;
        end
    endgenerate

    // Output register: strobe once per read, hold data between results.
    always_comb begin
        valid_out_d = out_vld;
        data_out_d  = data_out_q;
        unwritten_d = unwritten_q;
        if (out_vld) begin
            data_out_d  = out_dat;
            unwritten_d = out_unw;
        end
    end

    // Output flops.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_out_q <= 1'b0;
            unwritten_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            valid_out_q <= valid_out_d;
            unwritten_q <= unwritten_d;
            data_out_q  <= data_out_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.unwritten = unwritten_q;
endmodule

// File: tb/tb_memoria_be.sv
// Bench for memoria_be: three instances (latency 1 write-first, latency 1 read-first,
// latency 2 write-first) share one stimulus; a reference model fills per-instance queues
// of expected results, and a negedge monitor pops and compares them with cycle timing.
module tb_memoria_be;
    logic clk     = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dat;
        logic        unw;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q [3][$];
    logic [31:0] last_dat [3];
    logic [31:0] cyc = 0;
    logic        mon_en = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state.
    logic [31:0] m_mem [16];
    logic [15:0] m_wr = '0;

    memoria_be_if #(.BUS_SIZE(32), .ADDR_WIDTH(4), .NUM_MEM_UNITS(4)) if_a ();
    memoria_be_if #(.BUS_SIZE(32), .ADDR_WIDTH(4), .NUM_MEM_UNITS(4)) if_b ();
    memoria_be_if #(.BUS_SIZE(32), .ADDR_WIDTH(4), .NUM_MEM_UNITS(4)) if_c ();

    memoria_be #(.READ_LATENCY(1), .WRITE_FIRST(1'b1)) u_a (.clk(clk), .reset_L(reset_L), .bus(if_a));
    memoria_be #(.READ_LATENCY(1), .WRITE_FIRST(1'b0)) u_b (.clk(clk), .reset_L(reset_L), .bus(if_b));
    memoria_be #(.READ_LATENCY(2), .WRITE_FIRST(1'b1)) u_c (.clk(clk), .reset_L(reset_L), .bus(if_c));

    assign if_b.read = if_a.read;       assign if_c.read = if_a.read;
    assign if_b.write = if_a.write;     assign if_c.write = if_a.write;
    assign if_b.byte_en = if_a.byte_en; assign if_c.byte_en = if_a.byte_en;
    assign if_b.data_in = if_a.data_in; assign if_c.data_in = if_a.data_in;
    assign if_b.addressW = if_a.addressW; assign if_c.addressW = if_a.addressW;
    assign if_b.addressR = if_a.addressR; assign if_c.addressR = if_a.addressR;

    logic [31:0] dout [3];
    logic [2:0]  vld;
    logic [2:0]  unw;
    assign dout[0] = if_a.data_out; assign vld[0] = if_a.valid_out; assign unw[0] = if_a.unwritten;
    assign dout[1] = if_b.data_out; assign vld[1] = if_b.valid_out; assign unw[1] = if_b.unwritten;
    assign dout[2] = if_c.data_out; assign vld[2] = if_c.valid_out; assign unw[2] = if_c.unwritten;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Result monitor: every strobe must match the head of the queue at its expected cycle.
    always @(negedge clk) begin
        if (mon_en && reset_L) begin
            for (int k = 0; k < 3; k++) begin
                if (vld[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("spurious_vld%0d", k), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q[k].pop_front();
                        chk($sformatf("data%0d", k), dout[k], e.dat);
                        chk($sformatf("unw%0d", k), {31'd0, unw[k]}, {31'd0, e.unw});
                        chk($sformatf("lat%0d", k), cyc, e.cyc);
                    end
                    last_dat[k] = dout[k];
                end else begin
                    chk($sformatf("hold%0d", k), dout[k], last_dat[k]);
                    if (exp_q[k].size() != 0 && exp_q[k][0].cyc <= cyc) begin
                        chk($sformatf("missing_vld%0d", k), {31'd0, vld[k]}, 32'd1);
                        void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    // Drive one edge of stimulus and record what each instance must return.
    task automatic drive(input logic rd, input logic [3:0] ar, input logic wr,
                         input logic [3:0] aw, input logic [3:0] be, input logic [31:0] din);
        logic [31:0] prior, mask, merged, wf_dat;
        logic        pu, wf_unw;
        exp_t        e;
        if_a.read = rd; if_a.addressR = ar; if_a.write = wr;
        if_a.addressW = aw; if_a.byte_en = be; if_a.data_in = din;
        prior = m_wr[ar] ? m_mem[ar] : 32'd0;
        pu    = !m_wr[ar];
        for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{be[i]}};
        merged = (din & mask) | ((m_wr[aw] ? m_mem[aw] : 32'd0) & ~mask);
        if (wr && be != 4'd0 && aw == ar) begin
            wf_dat = merged; wf_unw = 1'b0;
        end else begin
            wf_dat = prior;  wf_unw = pu;
        end
        if (rd) begin
            e.dat = wf_dat; e.unw = wf_unw; e.cyc = cyc + 1; exp_q[0].push_back(e);
            e.dat = prior;  e.unw = pu;     e.cyc = cyc + 1; exp_q[1].push_back(e);
            e.dat = wf_dat; e.unw = wf_unw; e.cyc = cyc + 2; exp_q[2].push_back(e);
        end
        @(posedge clk);
        if (wr && be != 4'd0) begin
            m_mem[aw] = merged;
            m_wr[aw]  = 1'b1;
        end
        #1;
        if_a.read = 1'b0; if_a.write = 1'b0;
    endtask

    task automatic rd_only(input logic [3:0] a);
        drive(1'b1, a, 1'b0, 4'd0, 4'd0, 32'd0);
    endtask

    task automatic wr_only(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        drive(1'b0, 4'd0, 1'b1, a, be, d);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_dout%0d", tag, k), dout[k], 32'd0);
            chk($sformatf("%s_vld%0d", tag, k), {31'd0, vld[k]}, 32'd0);
            chk($sformatf("%s_unw%0d", tag, k), {31'd0, unw[k]}, 32'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) last_dat[k] = 32'd0;
        if_a.read = 1'b0; if_a.write = 1'b0; if_a.byte_en = '0;
        if_a.data_in = '0; if_a.addressW = '0; if_a.addressR = '0;

        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst");
        reset_L = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        // Read of a never-written word.
        rd_only(4'd3);
        @(negedge clk);
        chk("plan_unw_dat", if_a.data_out, 32'h0000_0000);
        chk("plan_unw_flag", {31'd0, if_a.unwritten}, 32'd1);
        @(posedge clk); #1;

        // Partial first write zero-fills, later partial write merges.
        wr_only(4'd5, 4'b0011, 32'hAABB_CCDD);
        rd_only(4'd5);
        @(negedge clk);
        chk("plan_first_partial", if_a.data_out, 32'h0000_CCDD);
        @(posedge clk); #1;
        wr_only(4'd5, 4'b1000, 32'h1122_3344);
        rd_only(4'd5);
        @(negedge clk);
        chk("plan_merge", if_a.data_out, 32'h1100_CCDD);
        @(posedge clk); #1;

        // Collision on a written word, then a follow-up read.
        wr_only(4'd2, 4'b1111, 32'h1234_5678);
        drive(1'b1, 4'd2, 1'b1, 4'd2, 4'b0101, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("plan_coll_wf", if_a.data_out, 32'h12FF_56FF);
        chk("plan_coll_rf", if_b.data_out, 32'h1234_5678);
        @(posedge clk); #1;
        rd_only(4'd2);
        @(negedge clk);
        chk("plan_after_coll", if_b.data_out, 32'h12FF_56FF);
        @(posedge clk); #1;

        // Collision on a never-written word.
        drive(1'b1, 4'd7, 1'b1, 4'd7, 4'b0010, 32'hDEAD_BEEF);

        // Back-to-back reads with latency 2.
        wr_only(4'd0, 4'hF, 32'h10);
        wr_only(4'd1, 4'hF, 32'h11);
        wr_only(4'd2, 4'hF, 32'h12);
        rd_only(4'd0);
        rd_only(4'd1);
        rd_only(4'd2);
        repeat (3) @(posedge clk);
        #1;

        // Reset while a latency-2 read is in flight.
        wr_only(4'd9, 4'hF, 32'h0000_0099);
        rd_only(4'd9);
        @(negedge clk); #1;
        reset_L = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            last_dat[k] = 32'd0;
        end
        m_wr = '0;
        #1 check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset_L = 1'b1;
        @(negedge clk);
        chk("midrst_no_vld", {31'd0, if_c.valid_out}, 32'd0);
        @(posedge clk); #1;
        rd_only(4'd9);
        repeat (2) @(posedge clk);
        #1;

        // Write with no lanes enabled leaves the word unwritten.
        wr_only(4'd11, 4'b0000, 32'hCAFE_F00D);
        rd_only(4'd11);
        @(negedge clk);
        chk("plan_be0_unw", {31'd0, if_a.unwritten}, 32'd1);
        chk("plan_be0_dat", if_a.data_out, 32'd0);
        @(posedge clk); #1;

        // Random traffic over a few addresses to exercise collisions.
        for (int n = 0; n < 60; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain%0d", k), exp_q[k].size(), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
